// File: rtl/riscv_multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and write enable from opcode, func3/func7 and flags.
module riscv_multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       func7,
  input  logic       zero,
  input  logic       neg,
  output logic       PCWrite,
  output logic       addrSrc,
  output logic       memWrite,
  output logic       IRWrite,
  output logic       regWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] immSrc,
  output logic       instrDone,
  output logic       trap,
  output logic [3:0] o_dbg_state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADR   = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_PC   = 4'd12,
    S_LUI       = 4'd13,
    S_TRAP      = 4'd14
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STOR = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  state_t     r_state;
  logic       w_alu_f3_bad;
  logic [2:0] w_alu_op;
  logic [2:0] w_dec_imm;
  logic       w_br_valid;
  logic       w_br_taken;
  logic       w_pcw, w_irw, w_regw, w_memw, w_done, w_trap;

  assign w_alu_f3_bad = (func3 == 3'b001) || (func3 == 3'b101);
  assign o_dbg_state  = r_state;

  // func7 selects sub only for R-type; immediate forms have no subtract
  always_comb begin
    w_alu_op = 3'b000;
    case (func3)
      3'b000:  w_alu_op = (opcode == OP_R && func7) ? 3'b001 : 3'b000;
      3'b111:  w_alu_op = 3'b010;
      3'b110:  w_alu_op = 3'b011;
      3'b100:  w_alu_op = 3'b100;
      3'b010:  w_alu_op = 3'b101;
      3'b011:  w_alu_op = 3'b110;
      default: w_alu_op = 3'b000;
    endcase
  end

  always_comb begin
    w_dec_imm = 3'b000;
    case (opcode)
      OP_STOR: w_dec_imm = 3'b001;
      OP_BR:   w_dec_imm = 3'b010;
      OP_JAL:  w_dec_imm = 3'b011;
      OP_LUI:  w_dec_imm = 3'b100;
      default: w_dec_imm = 3'b000;
    endcase
  end

  always_comb begin
    w_br_valid = 1'b1;
    w_br_taken = 1'b0;
    case (func3)
      3'b000:  w_br_taken = zero;
      3'b001:  w_br_taken = ~zero;
      3'b100:  w_br_taken = neg;
      3'b101:  w_br_taken = ~neg;
      default: w_br_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_R:             r_state <= w_alu_f3_bad ? S_TRAP : S_EXEC_R;
            OP_I:             r_state <= w_alu_f3_bad ? S_TRAP : S_EXEC_I;
            OP_LOAD, OP_STOR: r_state <= S_MEM_ADR;
            OP_BR:            r_state <= S_BRANCH;
            OP_JAL:           r_state <= S_JAL;
            OP_JALR:          r_state <= S_JALR;
            OP_LUI:           r_state <= S_LUI;
            default:          r_state <= S_TRAP;
          endcase
        end
        S_EXEC_R, S_EXEC_I: r_state <= S_ALU_WB;
        S_MEM_ADR: begin
          if (func3 != 3'b010)      r_state <= S_TRAP;
          else if (opcode == OP_LOAD) r_state <= S_MEM_READ;
          else                      r_state <= S_MEM_WRITE;
        end
        S_MEM_READ:  r_state <= S_MEM_WB;
        S_BRANCH:    r_state <= w_br_valid ? S_FETCH : S_TRAP;
        S_JAL:       r_state <= S_ALU_WB;
        S_JALR:      r_state <= S_JALR_PC;
        S_JALR_PC:   r_state <= S_ALU_WB;
        S_TRAP:      r_state <= S_TRAP;
        default:     r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_pcw      = 1'b0;
    w_irw      = 1'b0;
    w_regw     = 1'b0;
    w_memw     = 1'b0;
    w_done     = 1'b0;
    w_trap     = 1'b0;
    addrSrc    = 1'b0;
    resultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    immSrc     = 3'b000;
    case (r_state)
      S_FETCH:     begin w_irw = 1'b1; w_pcw = 1'b1; ALUSrcB = 2'b10; resultSrc = 2'b10; end
      S_DECODE:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; immSrc = w_dec_imm; end
      S_EXEC_R:    begin ALUSrcA = 2'b10; ALUControl = w_alu_op; end
      S_EXEC_I:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUControl = w_alu_op; end
      S_ALU_WB:    begin w_regw = 1'b1; w_done = 1'b1; end
      S_MEM_ADR:   begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        immSrc  = (opcode == OP_STOR) ? 3'b001 : 3'b000;
      end
      S_MEM_READ:  addrSrc = 1'b1;
      S_MEM_WB:    begin resultSrc = 2'b01; w_regw = 1'b1; w_done = 1'b1; end
      S_MEM_WRITE: begin addrSrc = 1'b1; w_memw = 1'b1; w_done = 1'b1; end
      // Taken/not-taken decided in this cycle straight from the ALU flags
      S_BRANCH:    begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        immSrc     = 3'b010;
        w_pcw      = w_br_valid & w_br_taken;
        w_done     = w_br_valid;
      end
      S_JAL:       begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; w_pcw = 1'b1; immSrc = 3'b011; end
      S_JALR:      begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_JALR_PC:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; w_pcw = 1'b1; end
      S_LUI:       begin resultSrc = 2'b11; immSrc = 3'b100; w_regw = 1'b1; w_done = 1'b1; end
      S_TRAP:      w_trap = 1'b1;
      default:     ;
    endcase
  end

  // Enables are masked while reset is low so no write escapes the reset cycle
  assign PCWrite   = w_pcw  & reset;
  assign IRWrite   = w_irw  & reset;
  assign regWrite  = w_regw & reset;
  assign memWrite  = w_memw & reset;
  assign instrDone = w_done & reset;
  assign trap      = w_trap & reset;

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Directed bench for riscv_multicycle_controller: per-cycle expected control
// vectors queued by the driver, compared by an independent negedge monitor.
module tb_riscv_multicycle_controller;

  localparam int W = 22;
  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_EXEC_R = 4'd2,
    ST_EXEC_I = 4'd3, ST_ALU_WB = 4'd4, ST_MEM_ADR = 4'd5, ST_MEM_READ = 4'd6,
    ST_MEM_WB = 4'd7, ST_MEM_WRITE = 4'd8, ST_BRANCH = 4'd9, ST_JAL = 4'd10,
    ST_JALR = 4'd11, ST_JALR_PC = 4'd12, ST_LUI = 4'd13, ST_TRAP = 4'd14;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       func7, zero, neg;
  logic       PCWrite, addrSrc, memWrite, IRWrite, regWrite, instrDone, trap;
  logic [1:0] resultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, immSrc;
  logic [3:0] o_dbg_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  riscv_multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7(func7),
    .zero(zero), .neg(neg), .PCWrite(PCWrite), .addrSrc(addrSrc),
    .memWrite(memWrite), .IRWrite(IRWrite), .regWrite(regWrite),
    .resultSrc(resultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .immSrc(immSrc), .instrDone(instrDone),
    .trap(trap), .o_dbg_state(o_dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // vector = {state, PCWrite, addrSrc, memWrite, IRWrite, regWrite,
  //           resultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc, instrDone, trap}
  function automatic logic [W-1:0] ev(input logic [3:0] st, input logic pcw,
      input logic adr, input logic mw, input logic irw, input logic rw,
      input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
      input logic [2:0] ac, input logic [2:0] imm, input logic dn, input logic tr);
    return {st, pcw, adr, mw, irw, rw, rs, sa, sb, ac, imm, dn, tr};
  endfunction

  function automatic logic [W-1:0] v_rst();
    return ev(ST_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 1'b0);
  endfunction
  function automatic logic [W-1:0] v_fetch();
    return ev(ST_FETCH, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 1'b0);
  endfunction
  function automatic logic [W-1:0] v_decode(input logic [2:0] imm);
    return ev(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0, 1'b0);
  endfunction
  function automatic logic [W-1:0] v_exec_r(input logic [2:0] ac);
    return ev(ST_EXEC_R, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, ac, 3'b000, 1'b0, 1'b0);
  endfunction
  function automatic logic [W-1:0] v_exec_i(input logic [2:0] ac);
    return ev(ST_EXEC_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, ac, 3'b000, 1'b0, 1'b0);
  endfunction
  function automatic logic [W-1:0] v_alu_wb();
    return ev(ST_ALU_WB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1, 1'b0);
  endfunction
  function automatic logic [W-1:0] v_mem_adr(input logic [2:0] imm);
    return ev(ST_MEM_ADR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 1'b0, 1'b0);
  endfunction
  function automatic logic [W-1:0] v_mem_read();
    return ev(ST_MEM_READ, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b0);
  endfunction
  function automatic logic [W-1:0] v_mem_wb();
    return ev(ST_MEM_WB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1, 1'b0);
  endfunction
  function automatic logic [W-1:0] v_mem_write();
    return ev(ST_MEM_WRITE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1, 1'b0);
  endfunction
  function automatic logic [W-1:0] v_branch(input logic pcw);
    return ev(ST_BRANCH, pcw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 1'b1, 1'b0);
  endfunction
  function automatic logic [W-1:0] v_jal();
    return ev(ST_JAL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, 1'b0, 1'b0);
  endfunction
  function automatic logic [W-1:0] v_jalr();
    return ev(ST_JALR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0, 1'b0);
  endfunction
  function automatic logic [W-1:0] v_jalr_pc();
    return ev(ST_JALR_PC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 1'b0, 1'b0);
  endfunction
  function automatic logic [W-1:0] v_lui();
    return ev(ST_LUI, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 1'b1, 1'b0);
  endfunction
  function automatic logic [W-1:0] v_trap();
    return ev(ST_TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 1'b1);
  endfunction

  // driver tasks: inputs change #1 after posedge, expectation for that cycle queued
  task automatic step(input logic [W-1:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic begin_instr(input logic [6:0] op, input logic [2:0] f3,
      input logic f7, input logic z, input logic n, input string nm);
    opcode = op;
    func3  = f3;
    func7  = f7;
    zero   = z;
    neg    = n;
    step(v_fetch(), {nm, "_fetch"});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    string        nm;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {o_dbg_state, PCWrite, addrSrc, memWrite, IRWrite, regWrite,
             resultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc, instrDone, trap};
      n_checks++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got %b expected %b", nm, act, e);
    end
  end

  initial begin
    reset = 1'b0; opcode = 7'd0; func3 = 3'd0; func7 = 1'b0; zero = 1'b0; neg = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) step(v_rst(), "reset_hold");
    reset = 1'b1;

    // sub
    begin_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, "sub");
    step(v_decode(3'b000), "sub_decode");
    step(v_exec_r(3'b001), "sub_exec");
    step(v_alu_wb(), "sub_wb");
    // or, slt (R-type)
    begin_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 1'b0, "or");
    step(v_decode(3'b000), "or_decode");
    step(v_exec_r(3'b011), "or_exec");
    step(v_alu_wb(), "or_wb");
    begin_instr(7'b0110011, 3'b010, 1'b0, 1'b0, 1'b0, "slt");
    step(v_decode(3'b000), "slt_decode");
    step(v_exec_r(3'b101), "slt_exec");
    step(v_alu_wb(), "slt_wb");
    // addi with func7 set must stay add; andi; sltiu
    begin_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, "addi");
    step(v_decode(3'b000), "addi_decode");
    step(v_exec_i(3'b000), "addi_exec");
    step(v_alu_wb(), "addi_wb");
    begin_instr(7'b0010011, 3'b111, 1'b1, 1'b0, 1'b0, "andi");
    step(v_decode(3'b000), "andi_decode");
    step(v_exec_i(3'b010), "andi_exec");
    step(v_alu_wb(), "andi_wb");
    begin_instr(7'b0010011, 3'b011, 1'b0, 1'b0, 1'b0, "sltiu");
    step(v_decode(3'b000), "sltiu_decode");
    step(v_exec_i(3'b110), "sltiu_exec");
    step(v_alu_wb(), "sltiu_wb");
    // lw / sw
    begin_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, "lw");
    step(v_decode(3'b000), "lw_decode");
    step(v_mem_adr(3'b000), "lw_adr");
    step(v_mem_read(), "lw_read");
    step(v_mem_wb(), "lw_wb");
    begin_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, "sw");
    step(v_decode(3'b001), "sw_decode");
    step(v_mem_adr(3'b001), "sw_adr");
    step(v_mem_write(), "sw_write");
    // branches
    begin_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, "beq_z1");
    step(v_decode(3'b010), "beq_decode");
    step(v_branch(1'b1), "beq_branch");
    begin_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, "bne_z1");
    step(v_decode(3'b010), "bne_decode");
    step(v_branch(1'b0), "bne_branch");
    begin_instr(7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, "blt_n1");
    step(v_decode(3'b010), "blt_decode");
    step(v_branch(1'b1), "blt_branch");
    begin_instr(7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, "bge_n1");
    step(v_decode(3'b010), "bge_decode");
    step(v_branch(1'b0), "bge_branch");
    // jal / jalr / lui
    begin_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, "jal");
    step(v_decode(3'b011), "jal_decode");
    step(v_jal(), "jal_jal");
    step(v_alu_wb(), "jal_wb");
    begin_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, "jalr");
    step(v_decode(3'b000), "jalr_decode");
    step(v_jalr(), "jalr_jalr");
    step(v_jalr_pc(), "jalr_pc");
    step(v_alu_wb(), "jalr_wb");
    begin_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, "lui");
    step(v_decode(3'b100), "lui_decode");
    step(v_lui(), "lui_lui");
    // reset in the middle of an add aborts it with no enables
    begin_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, "abort");
    step(v_decode(3'b000), "abort_decode");
    reset = 1'b0;
    step(v_rst(), "abort_reset");
    reset = 1'b1;
    // R-type shift func3 traps after decode
    begin_instr(7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0, "sll");
    step(v_decode(3'b000), "sll_decode");
    step(v_trap(), "sll_trap");
    reset = 1'b0;
    step(v_rst(), "sll_reset");
    reset = 1'b1;
    // unknown opcode: trap absorbs for 10 cycles, reset recovers
    begin_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, "illegal");
    step(v_decode(3'b000), "illegal_decode");
    repeat (10) step(v_trap(), "illegal_trap");
    reset = 1'b0;
    step(v_rst(), "illegal_reset");
    reset = 1'b1;
    begin_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, "lui2");
    step(v_decode(3'b100), "lui2_decode");
    step(v_lui(), "lui2_lui");

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
